// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse cursor tracker.
package mouse_pkg;

   localparam int unsigned DELTA_W = 9;   // PS/2 delta: sign + 8 bits
   localparam int unsigned CALC_W  = 12;  // signed working width
   localparam int unsigned POS_W   = 10;  // cursor coordinate width

   localparam int unsigned H_MAX_DEF  = 639;
   localparam int unsigned V_MAX_DEF  = 479;
   localparam int unsigned X_INIT_DEF = 320;
   localparam int unsigned Y_INIT_DEF = 240;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CALC    = 2'd1,
      ST_PUBLISH = 2'd2
   } state_t;

   // One decoded mouse packet as seen on the decoder interface.
   typedef struct packed {
      logic [7:0] x;
      logic       x_sign;
      logic       x_ov;
      logic [7:0] y;
      logic       y_sign;
      logic       y_ov;
      logic       l_click;
      logic       r_click;
   } mouse_pkt_t;

endpackage

// File: rtl/mouse_axis_update.sv
// One cursor axis: decode delta, saturate on overflow, scale, apply, clamp.
module mouse_axis_update
   import mouse_pkg::*;
#(
   parameter bit          INVERT = 1'b0,
   parameter int unsigned MAX    = H_MAX_DEF,
   parameter int unsigned SHIFT  = 0
)(
   input  logic [7:0]       bits,
   input  logic             sign,
   input  logic             ov,
   input  logic [POS_W-1:0] cur,
   output logic [POS_W-1:0] next_pos
);

   localparam logic signed [CALC_W-1:0] MAX_S = CALC_W'(MAX);

   logic [DELTA_W-1:0]       d9;
   logic signed [CALC_W-1:0] d12;
   logic signed [CALC_W-1:0] mag;
   logic signed [CALC_W-1:0] scaled;
   logic signed [CALC_W-1:0] step;
   logic signed [CALC_W-1:0] cur_s;
   logic signed [CALC_W-1:0] sum;

   // Magnitude is shifted so negative deltas round toward zero, not -inf.
   always_comb begin
      d9       = {sign, bits};
      if (ov) begin
         d9 = sign ? 9'h100 : 9'h0FF;
      end
      d12      = {{(CALC_W-DELTA_W){d9[DELTA_W-1]}}, d9};
      mag      = d9[DELTA_W-1] ? -d12 : d12;
      scaled   = mag >>> SHIFT;
      step     = d9[DELTA_W-1] ? -scaled : scaled;
      cur_s    = {{(CALC_W-POS_W){1'b0}}, cur};
      sum      = INVERT ? (cur_s - step) : (cur_s + step);
      next_pos = sum[POS_W-1:0];
      if (sum < 12'sd0) begin
         next_pos = '0;
      end else if (sum > MAX_S) begin
         next_pos = MAX_S[POS_W-1:0];
      end
   end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Integrates PS/2 mouse packets into a clamped cursor and click pulses.
module mouse_cursor_tracker
   import mouse_pkg::*;
#(
   parameter int unsigned H_MAX  = H_MAX_DEF,
   parameter int unsigned V_MAX  = V_MAX_DEF,
   parameter int unsigned X_INIT = X_INIT_DEF,
   parameter int unsigned Y_INIT = Y_INIT_DEF,
   parameter int unsigned SHIFT  = 0
)(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [7:0]       i_x,
   input  logic             i_x_sign,
   input  logic             i_x_ov,
   input  logic [7:0]       i_y,
   input  logic             i_y_sign,
   input  logic             i_y_ov,
   input  logic             i_l_click,
   input  logic             i_r_click,
   input  logic             i_valid,
   output logic [POS_W-1:0] o_cursor_x,
   output logic [POS_W-1:0] o_cursor_y,
   output logic             o_l_held,
   output logic             o_r_held,
   output logic             o_l_press,
   output logic             o_l_release,
   output logic             o_r_press,
   output logic             o_r_release,
   output logic             o_moved,
   output logic             o_busy
);

   state_t     state;
   state_t     state_next;
   logic       prev_valid;
   logic       pkt_edge;
   mouse_pkt_t in_pkt;
   mouse_pkt_t pkt;
   mouse_pkt_t shadow;
   logic       pending;

   logic [POS_W-1:0] calc_x;
   logic [POS_W-1:0] calc_y;
   logic [POS_W-1:0] nxt_x;
   logic [POS_W-1:0] nxt_y;
   logic             l_rise;
   logic             l_fall;
   logic             r_rise;
   logic             r_fall;

   assign in_pkt   = '{x: i_x, x_sign: i_x_sign, x_ov: i_x_ov,
                       y: i_y, y_sign: i_y_sign, y_ov: i_y_ov,
                       l_click: i_l_click, r_click: i_r_click};
   assign pkt_edge = i_valid & ~prev_valid;

   mouse_axis_update #(.INVERT(1'b0), .MAX(H_MAX), .SHIFT(SHIFT)) u_axis_x (
      .bits     (pkt.x),
      .sign     (pkt.x_sign),
      .ov       (pkt.x_ov),
      .cur      (o_cursor_x),
      .next_pos (calc_x)
   );

   // PS/2 reports +Y as up; the screen grows downward, so Y subtracts.
   mouse_axis_update #(.INVERT(1'b1), .MAX(V_MAX), .SHIFT(SHIFT)) u_axis_y (
      .bits     (pkt.y),
      .sign     (pkt.y_sign),
      .ov       (pkt.y_ov),
      .cur      (o_cursor_y),
      .next_pos (calc_y)
   );

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: a pending shadow packet counts as an accepted packet.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (pending || pkt_edge) state_next = ST_CALC;
         ST_CALC:    state_next = ST_PUBLISH;
         ST_PUBLISH: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Packet intake: working packet in IDLE, one-deep shadow while busy.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         prev_valid <= 1'b1;
         pkt        <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
      end else begin
         prev_valid <= i_valid;
         if (state == ST_IDLE) begin
            if (pending) begin
               pkt <= shadow;
               if (pkt_edge) begin
                  shadow <= in_pkt;
               end else begin
                  pending <= 1'b0;
               end
            end else if (pkt_edge) begin
               pkt <= in_pkt;
            end
         end else if (pkt_edge) begin
            shadow  <= in_pkt;
            pending <= 1'b1;
         end
      end
   end

   // CALC stage: register clamped positions and click edges.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         nxt_x  <= POS_W'(X_INIT);
         nxt_y  <= POS_W'(Y_INIT);
         l_rise <= 1'b0;
         l_fall <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else if (state == ST_CALC) begin
         nxt_x  <= calc_x;
         nxt_y  <= calc_y;
         l_rise <= pkt.l_click & ~o_l_held;
         l_fall <= ~pkt.l_click & o_l_held;
         r_rise <= pkt.r_click & ~o_r_held;
         r_fall <= ~pkt.r_click & o_r_held;
      end
   end

   // PUBLISH stage: update visible state; pulses last exactly one cycle.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_cursor_x  <= POS_W'(X_INIT);
         o_cursor_y  <= POS_W'(Y_INIT);
         o_l_held    <= 1'b0;
         o_r_held    <= 1'b0;
         o_l_press   <= 1'b0;
         o_l_release <= 1'b0;
         o_r_press   <= 1'b0;
         o_r_release <= 1'b0;
         o_moved     <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         o_busy      <= (state_next != ST_IDLE);
         o_l_press   <= 1'b0;
         o_l_release <= 1'b0;
         o_r_press   <= 1'b0;
         o_r_release <= 1'b0;
         o_moved     <= 1'b0;
         if (state == ST_PUBLISH) begin
            o_cursor_x  <= nxt_x;
            o_cursor_y  <= nxt_y;
            o_moved     <= (nxt_x != o_cursor_x) || (nxt_y != o_cursor_y);
            o_l_held    <= pkt.l_click;
            o_r_held    <= pkt.r_click;
            o_l_press   <= l_rise;
            o_l_release <= l_fall;
            o_r_press   <= r_rise;
            o_r_release <= r_fall;
         end
      end
   end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed, table-driven bench for mouse_cursor_tracker.
module tb_mouse_cursor_tracker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] x = '0;
   logic       xs = 1'b0;
   logic       xov = 1'b0;
   logic [7:0] y = '0;
   logic       ys = 1'b0;
   logic       yov = 1'b0;
   logic       lc = 1'b0;
   logic       rc = 1'b0;
   logic       v0 = 1'b0;
   logic       v1 = 1'b0;

   logic [9:0] cx0, cy0, cx1, cy1;
   logic       lh0, rh0, lp0, lr0, rp0, rr0, mv0, bz0;
   logic       lh1, rh1, lp1, lr1, rp1, rr1, mv1, bz1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mouse_cursor_tracker #(.H_MAX(639), .V_MAX(479), .X_INIT(320), .Y_INIT(240), .SHIFT(0)) dut0 (
      .i_clk(clk), .i_reset(rst), .i_x(x), .i_x_sign(xs), .i_x_ov(xov),
      .i_y(y), .i_y_sign(ys), .i_y_ov(yov), .i_l_click(lc), .i_r_click(rc),
      .i_valid(v0), .o_cursor_x(cx0), .o_cursor_y(cy0), .o_l_held(lh0), .o_r_held(rh0),
      .o_l_press(lp0), .o_l_release(lr0), .o_r_press(rp0), .o_r_release(rr0),
      .o_moved(mv0), .o_busy(bz0));

   mouse_cursor_tracker #(.H_MAX(639), .V_MAX(479), .X_INIT(320), .Y_INIT(240), .SHIFT(1)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_x(x), .i_x_sign(xs), .i_x_ov(xov),
      .i_y(y), .i_y_sign(ys), .i_y_ov(yov), .i_l_click(lc), .i_r_click(rc),
      .i_valid(v1), .o_cursor_x(cx1), .o_cursor_y(cy1), .o_l_held(lh1), .o_r_held(rh1),
      .o_l_press(lp1), .o_l_release(lr1), .o_r_press(rp1), .o_r_release(rr1),
      .o_moved(mv1), .o_busy(bz1));

   typedef struct {
      logic [7:0] x;
      logic       xs;
      logic       xov;
      logic [7:0] y;
      logic       ys;
      logic       yov;
      logic       l;
      logic       r;
      int         ex;
      int         ey;
      int         em;
      int         epulse;  // {l_press, l_release, r_press, r_release}
      int         eheld;   // {l_held, r_held}
   } vec_t;

   typedef struct {
      int x;
      int y;
      int moved;
      int pulse;
      int held;
      int busy_k;
      int busy_k3;
      int pulse_k3;
      int moved_cnt;
   } obs_t;

   vec_t vecs[14];

   function automatic vec_t mk(input logic [7:0] vx, input logic vxs, input logic vxov,
                               input logic [7:0] vy, input logic vys, input logic vyov,
                               input logic vl, input logic vr, input int ex, input int ey,
                               input int em, input int ep, input int eh);
      vec_t t;
      t.x = vx; t.xs = vxs; t.xov = vxov;
      t.y = vy; t.ys = vys; t.yov = vyov;
      t.l = vl; t.r = vr;
      t.ex = ex; t.ey = ey; t.em = em; t.epulse = ep; t.eheld = eh;
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int rd_x(input bit sel);
      return sel ? int'(cx1) : int'(cx0);
   endfunction
   function automatic int rd_y(input bit sel);
      return sel ? int'(cy1) : int'(cy0);
   endfunction
   function automatic int rd_moved(input bit sel);
      return sel ? int'(mv1) : int'(mv0);
   endfunction
   function automatic int rd_busy(input bit sel);
      return sel ? int'(bz1) : int'(bz0);
   endfunction
   function automatic int rd_pulse(input bit sel);
      return sel ? int'({lp1, lr1, rp1, rr1}) : int'({lp0, lr0, rp0, rr0});
   endfunction
   function automatic int rd_held(input bit sel);
      return sel ? int'({lh1, rh1}) : int'({lh0, rh0});
   endfunction

   task automatic drive(input vec_t t);
      x = t.x; xs = t.xs; xov = t.xov;
      y = t.y; ys = t.ys; yov = t.yov;
      lc = t.l; rc = t.r;
   endtask

   // Apply one packet with valid held for 'hold' cycles; sample on negedges.
   task automatic send(input vec_t t, input bit sel, input int hold, output obs_t o);
      o = '{default: 0};
      @(negedge clk);
      drive(t);
      if (sel) v1 = 1'b1; else v0 = 1'b1;
      for (int c = 0; c < hold + 4; c++) begin
         @(negedge clk);
         if (c == hold - 1) begin
            v0 = 1'b0;
            v1 = 1'b0;
         end
         if (c == 0) o.busy_k = rd_busy(sel);
         if (c == 2) begin
            o.x     = rd_x(sel);
            o.y     = rd_y(sel);
            o.moved = rd_moved(sel);
            o.pulse = rd_pulse(sel);
            o.held  = rd_held(sel);
         end
         if (c == 3) begin
            o.busy_k3  = rd_busy(sel);
            o.pulse_k3 = rd_pulse(sel) | rd_moved(sel);
         end
         o.moved_cnt += rd_moved(sel);
      end
   endtask

   initial begin
      obs_t o;
      vec_t t;
      int   cnt;
      int   any;

      vecs[0]  = mk(8'h0A, 0, 0, 8'h05, 0, 0, 0, 0, 330, 235, 1, 0, 0);
      vecs[1]  = mk(8'h01, 1, 0, 8'hC8, 0, 0, 0, 0,  75,  35, 1, 0, 0);
      vecs[2]  = mk(8'hBA, 1, 0, 8'h1E, 0, 0, 0, 0,   5,   5, 1, 0, 0);
      vecs[3]  = mk(8'hF6, 1, 0, 8'hF6, 1, 0, 0, 0,   0,  15, 1, 0, 0);
      vecs[4]  = mk(8'hFF, 1, 0, 8'h00, 0, 0, 0, 0,   0,  15, 0, 0, 0);
      vecs[5]  = mk(8'hFF, 0, 0, 8'h01, 1, 0, 0, 0, 255, 270, 1, 0, 0);
      vecs[6]  = mk(8'hFF, 0, 0, 8'hE2, 1, 0, 0, 0, 510, 300, 1, 0, 0);
      vecs[7]  = mk(8'h5A, 0, 0, 8'h00, 0, 0, 0, 0, 600, 300, 1, 0, 0);
      vecs[8]  = mk(8'h00, 0, 1, 8'h00, 1, 1, 0, 0, 639, 479, 1, 0, 0);
      vecs[9]  = mk(8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 639, 479, 0, 8, 2);
      vecs[10] = mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 639, 479, 0, 6, 1);
      vecs[11] = mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 639, 479, 0, 1, 0);
      vecs[12] = mk(8'h01, 0, 0, 8'hFF, 1, 0, 0, 0, 639, 479, 0, 0, 0);
      vecs[13] = mk(8'h00, 1, 1, 8'h00, 0, 1, 0, 0, 383, 224, 1, 0, 0);

      // Reset state.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_x", int'(cx0), 320);
      chk("reset_y", int'(cy0), 240);
      chk("reset_busy", int'(bz0), 0);
      chk("reset_held", int'({lh0, rh0}), 0);
      chk("reset_pulses", int'({lp0, lr0, rp0, rr0, mv0}), 0);

      // Table-driven single packets on the SHIFT=0 instance.
      for (int i = 0; i < 14; i++) begin
         send(vecs[i], 1'b0, 1, o);
         chk($sformatf("v%0d_x", i), o.x, vecs[i].ex);
         chk($sformatf("v%0d_y", i), o.y, vecs[i].ey);
         chk($sformatf("v%0d_moved", i), o.moved, vecs[i].em);
         chk($sformatf("v%0d_pulse", i), o.pulse, vecs[i].epulse);
         chk($sformatf("v%0d_held", i), o.held, vecs[i].eheld);
         chk($sformatf("v%0d_busy_k", i), o.busy_k, 1);
         chk($sformatf("v%0d_busy_k3", i), o.busy_k3, 0);
         chk($sformatf("v%0d_pulse_k3", i), o.pulse_k3, 0);
         chk($sformatf("v%0d_moved_cnt", i), o.moved_cnt, vecs[i].em);
      end

      // Valid held high for 50 cycles is one packet.
      t = mk(8'h01, 0, 0, 8'h00, 0, 0, 0, 0, 384, 224, 1, 0, 0);
      send(t, 1'b0, 50, o);
      chk("hold_moved_cnt", o.moved_cnt, 1);
      chk("hold_x", int'(cx0), 384);
      chk("hold_y", int'(cy0), 224);

      // Second edge while busy: shadowed, applied after the first.
      cnt = 0;
      @(negedge clk);
      drive(mk(8'h02, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
      @(negedge clk);
      drive(mk(8'h03, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
      chk("b2b_first_x", int'(cx0), 386);
      cnt += int'(mv0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         cnt += int'(mv0);
      end
      chk("b2b_moved_cnt", cnt, 2);
      chk("b2b_final_x", int'(cx0), 389);
      chk("b2b_busy_end", int'(bz0), 0);

      // Reset during PUBLISH with valid held high across reset.
      @(negedge clk);
      drive(mk(8'h0A, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      v0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_x", int'(cx0), 320);
      chk("rst_mid_y", int'(cy0), 240);
      chk("rst_mid_busy", int'(bz0), 0);
      rst = 1'b0;
      any = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         any |= int'({lp0, lr0, rp0, rr0, mv0, bz0});
      end
      v0 = 1'b0;
      chk("rst_after_quiet", any, 0);
      chk("rst_after_x", int'(cx0), 320);
      chk("rst_after_held", int'({lh0, rh0}), 0);

      // SHIFT=1 instance: -1 rounds to zero, +3 becomes +1.
      t = mk(8'hFF, 1, 0, 8'h00, 0, 0, 0, 0, 320, 240, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         send(t, 1'b1, 1, o);
         chk($sformatf("s1_neg%0d_x", i), o.x, 320);
         chk($sformatf("s1_neg%0d_moved", i), o.moved_cnt, 0);
      end
      t = mk(8'h03, 0, 0, 8'h00, 0, 0, 0, 0, 321, 240, 1, 0, 0);
      send(t, 1'b1, 1, o);
      chk("s1_pos_x", o.x, 321);
      chk("s1_pos_y", o.y, 240);
      chk("s1_pos_moved", o.moved, 1);
      chk("s1_dut0_untouched", int'(cx0), 320);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
